// File: rtl/pong_pkg.sv
// Shared types and constants for the pong scoreboard: FSM state encoding,
// default match parameters and active-low seven-segment patterns (gfedcba).
package pong_pkg;

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_HOLD = 2'd1,
        S_OVER = 2'd2
    } state_e;

    localparam int unsigned WIN_SCORE_DEFAULT  = 7;
    localparam int unsigned HOLD_TICKS_DEFAULT = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/score_seg7.sv
// Combinational 4-bit to seven-segment decoder, active-low gfedcba.
// Values above 9 blank the digit.
module score_seg7
    import pong_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (value_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/pong_scoreboard.sv
// Pong match scoreboard: counts point edges, latches the winner, gates serve.
// Define SCORE_SEG7_EN to add registered seven-segment score outputs seg1/seg2.
module pong_scoreboard
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE  = WIN_SCORE_DEFAULT,
    parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       p1score,
    input  logic       p2score,
    input  logic       serve_btn,
    input  logic       new_game,
    output logic       serve,
    output logic [3:0] p1points,
    output logic [3:0] p2points,
    output logic       game_over,
    output logic       winner
`ifdef SCORE_SEG7_EN
    ,
    output logic [6:0] seg1,
    output logic [6:0] seg2
`endif
);

    localparam logic [3:0] WinCount = 4'(WIN_SCORE);
    localparam logic [7:0] HoldLoad = 8'(HOLD_TICKS);

    state_e     state_q, state_d;
    logic [3:0] p1_points_q, p1_points_d;
    logic [3:0] p2_points_q, p2_points_d;
    logic [7:0] hold_q, hold_d;
    logic       winner_q, winner_d;
    logic       over_q, over_d;
    logic       p1_lvl_q, p2_lvl_q;

    logic       p1_edge, p2_edge;
    logic [3:0] p1_inc, p2_inc;

    // Upstream holds the score level for several cycles; only the rise counts.
    assign p1_edge = p1score & ~p1_lvl_q;
    assign p2_edge = p2score & ~p2_lvl_q;
    assign p1_inc  = p1_points_q + 4'd1;
    assign p2_inc  = p2_points_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        p1_points_d = p1_points_q;
        p2_points_d = p2_points_q;
        hold_d      = hold_q;
        winner_d    = winner_q;
        over_d      = over_q;
        case (state_q)
            S_PLAY: begin
                if (p1_edge && !p2_edge) begin
                    p1_points_d = p1_inc;
                    if (p1_inc == WinCount) begin
                        state_d  = S_OVER;
                        over_d   = 1'b1;
                        winner_d = 1'b0;
                    end else begin
                        hold_d  = HoldLoad;
                        state_d = S_HOLD;
                    end
                end else if (p2_edge && !p1_edge) begin
                    p2_points_d = p2_inc;
                    if (p2_inc == WinCount) begin
                        state_d  = S_OVER;
                        over_d   = 1'b1;
                        winner_d = 1'b1;
                    end else begin
                        hold_d  = HoldLoad;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (ready) begin
                    if (hold_q <= 8'd1) begin
                        hold_d  = 8'd0;
                        state_d = S_PLAY;
                    end else begin
                        hold_d = hold_q - 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (new_game) begin
                    p1_points_d = 4'd0;
                    p2_points_d = 4'd0;
                    winner_d    = 1'b0;
                    over_d      = 1'b0;
                    state_d     = S_PLAY;
                end
            end
            default: begin
                state_d = S_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLAY;
            p1_points_q <= 4'd0;
            p2_points_q <= 4'd0;
            hold_q      <= 8'd0;
            winner_q    <= 1'b0;
            over_q      <= 1'b0;
            p1_lvl_q    <= 1'b0;
            p2_lvl_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            p1_points_q <= p1_points_d;
            p2_points_q <= p2_points_d;
            hold_q      <= hold_d;
            winner_q    <= winner_d;
            over_q      <= over_d;
            p1_lvl_q    <= p1score;
            p2_lvl_q    <= p2score;
        end
    end

    assign serve     = serve_btn & (state_q == S_PLAY);
    assign p1points  = p1_points_q;
    assign p2points  = p2_points_q;
    assign game_over = over_q;
    assign winner    = winner_q;

`ifdef SCORE_SEG7_EN
    logic [6:0] seg1_raw, seg2_raw;
    logic [6:0] seg1_q, seg2_q;

    score_seg7 u_seg1 (
        .value_i (p1_points_q),
        .seg_o   (seg1_raw)
    );

    score_seg7 u_seg2 (
        .value_i (p2_points_q),
        .seg_o   (seg2_raw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg1_q <= SEG_0;
            seg2_q <= SEG_0;
        end else begin
            seg1_q <= seg1_raw;
            seg2_q <= seg2_raw;
        end
    end

    assign seg1 = seg1_q;
    assign seg2 = seg2_q;
`endif

endmodule

// File: tb/tb_pong_scoreboard.sv
// Directed self-checking bench for pong_scoreboard; expectations are queued
// as stimulus is driven and checked when the DUT outputs are sampled.
module tb_pong_scoreboard;

    logic       clk;
    logic       rst;
    logic       ready;
    logic       p1score;
    logic       p2score;
    logic       serve_btn;
    logic       new_game;
    logic       serve;
    logic [3:0] p1points;
    logic [3:0] p2points;
    logic       game_over;
    logic       winner;
`ifdef SCORE_SEG7_EN
    logic [6:0] seg1;
    logic [6:0] seg2;
`endif

    pong_scoreboard #(
        .WIN_SCORE  (7),
        .HOLD_TICKS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .p1score   (p1score),
        .p2score   (p2score),
        .serve_btn (serve_btn),
        .new_game  (new_game),
        .serve     (serve),
        .p1points  (p1points),
        .p2points  (p2points),
        .game_over (game_over),
        .winner    (winner)
`ifdef SCORE_SEG7_EN
        ,
        .seg1      (seg1),
        .seg2      (seg2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       go;
        logic       win;
        logic       srv;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [3:0] p1, input logic [3:0] p2,
                        input logic go, input logic win, input logic srv);
        exp_t e;
        e.tag = tag;
        e.p1  = p1;
        e.p2  = p2;
        e.go  = go;
        e.win = win;
        e.srv = srv;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=0 entries required=1");
            return;
        end
        e = sb.pop_front();
        vectors++;
        assert (p1points === e.p1) else begin
            miscompares++;
            $error("FAIL %s.p1points observed=%0d expected=%0d", e.tag, p1points, e.p1);
        end
        vectors++;
        assert (p2points === e.p2) else begin
            miscompares++;
            $error("FAIL %s.p2points observed=%0d expected=%0d", e.tag, p2points, e.p2);
        end
        vectors++;
        assert (game_over === e.go) else begin
            miscompares++;
            $error("FAIL %s.game_over observed=%b expected=%b", e.tag, game_over, e.go);
        end
        vectors++;
        assert (winner === e.win) else begin
            miscompares++;
            $error("FAIL %s.winner observed=%b expected=%b", e.tag, winner, e.win);
        end
        vectors++;
        assert (serve === e.srv) else begin
            miscompares++;
            $error("FAIL %s.serve observed=%b expected=%b", e.tag, serve, e.srv);
        end
    endtask

    // Four ready pulses separated by idle cycles; serve reopens on the last.
    task automatic run_hold(input logic [3:0] p1, input logic [3:0] p2);
        for (int i = 1; i <= 4; i++) begin
            ready = 1'b1;
            tick();
            ready = 1'b0;
            push("hold_pulse", p1, p2, 1'b0, 1'b0, (i == 4));
            check_pop();
            if (i < 4) begin
                tick();
                push("hold_idle", p1, p2, 1'b0, 1'b0, 1'b0);
                check_pop();
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ready       = 1'b0;
        p1score     = 1'b0;
        p2score     = 1'b0;
        serve_btn   = 1'b1;
        new_game    = 1'b0;
        tick();
        tick();
        push("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check_pop();
        rst = 1'b0;

        // Wide p1 pulse with a ready in the entry cycle that must not count.
        p1score = 1'b1;
        ready   = 1'b1;
        push("p1_point", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        ready = 1'b0;
        check_pop();
        push("p1_wide2", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_pop();
        push("p1_wide3", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_pop();
        p1score = 1'b0;
        run_hold(4'd1, 4'd0);

        serve_btn = 1'b0;
        #1;
        push("serve_btn_low", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        check_pop();
        serve_btn = 1'b1;

        // Simultaneous edges credit nobody; new_game outside S_OVER is ignored.
        p1score  = 1'b1;
        p2score  = 1'b1;
        new_game = 1'b1;
        push("simultaneous", 4'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        new_game = 1'b0;
        check_pop();
        p1score = 1'b0;
        p2score = 1'b0;
        tick();

        for (int k = 1; k <= 7; k++) begin
            p2score = 1'b1;
            push("p2_point", 4'd1, 4'(k), (k == 7), (k == 7), 1'b0);
            tick();
            p2score = 1'b0;
            check_pop();
            if (k < 7) run_hold(4'd1, 4'(k));
        end

        p2score = 1'b1;
        tick();
        p2score = 1'b0;
        tick();
        push("p2_eighth", 4'd1, 4'd7, 1'b1, 1'b1, 1'b0);
        check_pop();

        new_game = 1'b1;
        push("new_game", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        new_game = 1'b0;
        check_pop();

        // Async reset mid-hold with the score level still high.
        p1score = 1'b1;
        push("pre_reset", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_pop();
        tick();
        rst = 1'b1;
        #1;
        push("mid_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        check_pop();
        tick();
        tick();
        rst = 1'b0;
        push("post_reset", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_pop();

`ifdef SCORE_SEG7_EN
        vectors++;
        assert (seg1 === 7'b1000000) else begin
            miscompares++;
            $error("FAIL seg1_lag observed=%b expected=%b", seg1, 7'b1000000);
        end
        tick();
        vectors++;
        assert (seg1 === 7'b1111001) else begin
            miscompares++;
            $error("FAIL seg1_one observed=%b expected=%b", seg1, 7'b1111001);
        end
        vectors++;
        assert (seg2 === 7'b1000000) else begin
            miscompares++;
            $error("FAIL seg2_zero observed=%b expected=%b", seg2, 7'b1000000);
        end
`endif
        p1score = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
